// File: rtl/drum_seq_pkg.sv
// Shared types and default dimensions for the drum step sequencer.
package drum_seq_pkg;

  localparam int unsigned DEF_NUM_VOICES = 4;
  localparam int unsigned DEF_NUM_STEPS  = 16;
  localparam int unsigned DEF_PERIOD_W   = 16;
  localparam int unsigned DEF_GATE_W     = 12;

  // Shortest step that still leaves one low cycle after a gate.
  localparam int unsigned MIN_PERIOD     = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/seq_pattern_ram.sv
// Trigger pattern store: one row of voice bits per step.
// Synchronous write, combinational read (old data on same-cycle collision),
// asynchronously cleared.
module seq_pattern_ram #(
  parameter int unsigned NUM_STEPS  = 16,
  parameter int unsigned NUM_VOICES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we_i,
  input  logic [$clog2(NUM_STEPS)-1:0] waddr_i,
  input  logic [NUM_VOICES-1:0]        wdata_i,
  input  logic [$clog2(NUM_STEPS)-1:0] raddr_i,
  output logic [NUM_VOICES-1:0]        rdata_o
);

  logic [NUM_VOICES-1:0] mem_q [NUM_STEPS];

  // Row storage: cleared on reset, written on the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_STEPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port sees the pre-write contents during a write cycle.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/drum_step_sequencer.sv
// Drum step sequencer: walks the pattern at a programmable tempo and
// drives one gated enable per sample player.
module drum_step_sequencer
  import drum_seq_pkg::*;
#(
  parameter int unsigned NUM_VOICES = DEF_NUM_VOICES,
  parameter int unsigned NUM_STEPS  = DEF_NUM_STEPS,
  parameter int unsigned PERIOD_W   = DEF_PERIOD_W,
  parameter int unsigned GATE_W     = DEF_GATE_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic [PERIOD_W-1:0]          step_period,
  input  logic [GATE_W-1:0]            gate_len,
  input  logic [NUM_VOICES-1:0]        mute,
  input  logic                         pat_we,
  input  logic [$clog2(NUM_STEPS)-1:0] pat_addr,
  input  logic [NUM_VOICES-1:0]        pat_wdata,
  output logic [NUM_VOICES-1:0]        voice_en,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx,
  output logic                         step_pulse,
  output logic                         playing
);

  localparam int unsigned AW = $clog2(NUM_STEPS);
  // Compare width wide enough for both period and gate plus one.
  localparam int unsigned CW = ((PERIOD_W > GATE_W) ? PERIOD_W : GATE_W) + 1;

  seq_state_t state_q, state_d;

  logic [PERIOD_W-1:0]   step_cnt_q, step_cnt_d;
  logic [AW-1:0]         step_idx_q, step_idx_d;
  logic [NUM_VOICES-1:0] voice_q, voice_d;
  logic                  pulse_q, pulse_d;
  logic                  playing_q, playing_d;

  logic [CW-1:0]         period_ext, gate_ext, cnt_ext, cnt_inc;
  logic [CW-1:0]         eff_period, eff_gate, last_cnt;
  logic                  step_end, gate_hit;
  logic [AW-1:0]         rd_addr;
  logic [NUM_VOICES-1:0] rd_row, load_row;

  seq_pattern_ram #(
    .NUM_STEPS  (NUM_STEPS),
    .NUM_VOICES (NUM_VOICES)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (pat_we),
    .waddr_i (pat_addr),
    .wdata_i (pat_wdata),
    .raddr_i (rd_addr),
    .rdata_o (rd_row)
  );

  // Effective period/gate and the step/gate boundary compares.
  always_comb begin
    period_ext = CW'(step_period);
    gate_ext   = CW'(gate_len);
    cnt_ext    = CW'(step_cnt_q);
    cnt_inc    = cnt_ext + CW'(1);
    eff_period = (period_ext < CW'(MIN_PERIOD)) ? CW'(MIN_PERIOD) : period_ext;
    last_cnt   = eff_period - CW'(1);
    eff_gate   = (gate_ext < last_cnt) ? gate_ext : last_cnt;
    // >= so that shrinking the period mid-step wraps at once.
    step_end   = (cnt_ext >= last_cnt);
    gate_hit   = (cnt_inc == eff_gate);
    // Starting from IDLE always loads row 0; otherwise the following row.
    rd_addr    = (state_q == RUN) ? step_idx_q + AW'(1) : '0;
    load_row   = (gate_len == '0) ? '0 : (rd_row & ~mute);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: run level alone selects the state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (run)  state_d = RUN;
      RUN:  if (!run) state_d = IDLE;
    endcase
  end

  // Next values of the counter and registered outputs.
  always_comb begin
    step_cnt_d = step_cnt_q;
    step_idx_d = step_idx_q;
    voice_d    = voice_q;
    pulse_d    = 1'b0;
    playing_d  = playing_q;
    case (state_q)
      IDLE: begin
        if (run) begin
          step_cnt_d = '0;
          step_idx_d = '0;
          voice_d    = load_row;
          pulse_d    = 1'b1;
          playing_d  = 1'b1;
        end else begin
          step_cnt_d = '0;
          step_idx_d = '0;
          voice_d    = '0;
          playing_d  = 1'b0;
        end
      end
      RUN: begin
        if (!run) begin
          step_cnt_d = '0;
          step_idx_d = '0;
          voice_d    = '0;
          playing_d  = 1'b0;
        end else if (step_end) begin
          step_cnt_d = '0;
          step_idx_d = step_idx_q + AW'(1);
          voice_d    = load_row;
          pulse_d    = 1'b1;
          playing_d  = 1'b1;
        end else begin
          step_cnt_d = step_cnt_q + PERIOD_W'(1);
          playing_d  = 1'b1;
          if (gate_hit) voice_d = '0;
        end
      end
    endcase
  end

  // Output and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q <= '0;
      step_idx_q <= '0;
      voice_q    <= '0;
      pulse_q    <= 1'b0;
      playing_q  <= 1'b0;
    end else begin
      step_cnt_q <= step_cnt_d;
      step_idx_q <= step_idx_d;
      voice_q    <= voice_d;
      pulse_q    <= pulse_d;
      playing_q  <= playing_d;
    end
  end

  assign voice_en   = voice_q;
  assign step_idx   = step_idx_q;
  assign step_pulse = pulse_q;
  assign playing    = playing_q;

endmodule
